// File: rtl/metropolis_accept_unit_if.sv
// Request/response and PRNG signals of the Metropolis accept unit.
// valid/ready: a transfer happens on a rising clk edge where both are high; once valid is raised, the payload is held stable until that edge.
interface metropolis_accept_unit_if #(
  parameter int RAND_W = 16,
  parameter int TAG_W  = 12
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_de_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              rng_enable;
  logic [RAND_W-1:0] rng_data;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_accept;
  logic [TAG_W-1:0]  resp_tag;

  // master = sweep controller plus PRNG source; slave = the accept unit
  modport master (
    output req_valid, req_de_idx, req_tag, rng_data, resp_ready,
    input  req_ready, rng_enable, resp_valid, resp_accept, resp_tag
  );
  modport slave (
    input  req_valid, req_de_idx, req_tag, rng_data, resp_ready,
    output req_ready, rng_enable, resp_valid, resp_accept, resp_tag
  );
endinterface

// File: rtl/metropolis_accept_unit.sv
// Metropolis spin-flip acceptance: compares one PRNG word against a Boltzmann
// threshold for positive energy changes and returns accept/reject with the tag.
module metropolis_accept_unit #(
  parameter int RAND_W = 16,
  parameter int TAG_W  = 12,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  metropolis_accept_unit_if.slave bus,
  input  logic                cfg_we,
  input  logic                cfg_sel,
  input  logic [RAND_W-1:0]   cfg_data,
  input  logic                stat_clr,
  output logic [CNT_W-1:0]    accept_cnt,
  output logic [CNT_W-1:0]    draw_cnt,
  output logic                err_illegal,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [2:0]        idx_q;
  logic [TAG_W-1:0]  tag_q;
  logic [RAND_W-1:0] thr4;
  logic [RAND_W-1:0] thr8;

  logic draw_inc;
  logic acc_inc;
  logic ill_set;

  assign state_dbg = state;

  always_comb begin
    draw_inc = 1'b0;
    acc_inc  = 1'b0;
    ill_set  = 1'b0;
    if (state == EVAL) begin
      draw_inc = (idx_q == 3'd3) || (idx_q == 3'd4);
      ill_set  = (idx_q > 3'd4);
    end
    if (state == RESP) begin
      acc_inc = bus.resp_ready && bus.resp_accept;
    end
  end

  // rng_enable is pre-registered on the request handshake so it is high exactly in EVAL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      idx_q           <= 3'd0;
      tag_q           <= '0;
      bus.req_ready   <= 1'b1;
      bus.rng_enable  <= 1'b0;
      bus.resp_valid  <= 1'b0;
      bus.resp_accept <= 1'b0;
      bus.resp_tag    <= '0;
    end else begin
      bus.rng_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            idx_q          <= bus.req_de_idx;
            tag_q          <= bus.req_tag;
            bus.req_ready  <= 1'b0;
            bus.rng_enable <= (bus.req_de_idx == 3'd3) || (bus.req_de_idx == 3'd4);
            state          <= EVAL;
          end
        end
        EVAL: begin
          // Thresholds are read before any same-cycle cfg write lands
          case (idx_q)
            3'd0, 3'd1, 3'd2: bus.resp_accept <= 1'b1;
            3'd3:             bus.resp_accept <= (bus.rng_data < thr4);
            3'd4:             bus.resp_accept <= (bus.rng_data < thr8);
            default:          bus.resp_accept <= 1'b0;
          endcase
          bus.resp_tag   <= tag_q;
          bus.resp_valid <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
            state          <= IDLE;
          end
        end
        default: begin
          bus.resp_valid <= 1'b0;
          bus.req_ready  <= 1'b1;
          state          <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr4 <= '0;
      thr8 <= '0;
    end else if (cfg_we) begin
      if (cfg_sel) thr8 <= cfg_data;
      else         thr4 <= cfg_data;
    end
  end

  // stat_clr wins over any increment landing in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accept_cnt  <= '0;
      draw_cnt    <= '0;
      err_illegal <= 1'b0;
    end else if (stat_clr) begin
      accept_cnt  <= '0;
      draw_cnt    <= '0;
      err_illegal <= 1'b0;
    end else begin
      if (acc_inc && (accept_cnt != '1)) accept_cnt <= accept_cnt + CNT_W'(1);
      if (draw_inc && (draw_cnt != '1))  draw_cnt   <= draw_cnt + CNT_W'(1);
      if (ill_set)                       err_illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_metropolis_accept_unit.sv
// Directed bench for metropolis_accept_unit: latency, threshold compare,
// cfg timing, backpressure, illegal codes, counters and mid-flight reset.
module tb_metropolis_accept_unit;

  localparam int RAND_W = 16;
  localparam int TAG_W  = 12;
  localparam int CNT_W  = 32;

  logic              clk;
  logic              rst_n;
  logic              cfg_we;
  logic              cfg_sel;
  logic [RAND_W-1:0] cfg_data;
  logic              stat_clr;
  logic [CNT_W-1:0]  accept_cnt;
  logic [CNT_W-1:0]  draw_cnt;
  logic              err_illegal;
  logic [1:0]        state_dbg;

  int checks   = 0;
  int failures = 0;

  metropolis_accept_unit_if #(.RAND_W(RAND_W), .TAG_W(TAG_W)) bus ();

  metropolis_accept_unit #(.RAND_W(RAND_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .cfg_we      (cfg_we),
    .cfg_sel     (cfg_sel),
    .cfg_data    (cfg_data),
    .stat_clr    (stat_clr),
    .accept_cnt  (accept_cnt),
    .draw_cnt    (draw_cnt),
    .err_illegal (err_illegal),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic cfg_write(input logic sel, input logic [RAND_W-1:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_data = data;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_clr();
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
  endtask

  // One request through to its response handshake; lat counts cycles after the
  // request handshake until resp_valid (-1 on timeout), pulses counts rng_enable highs.
  task automatic run_req(input logic [2:0] idx, input logic [TAG_W-1:0] tag,
                         input logic [RAND_W-1:0] rd, input logic eval_wr,
                         input logic [RAND_W-1:0] eval_data,
                         output int lat, output int pulses,
                         output logic acc, output logic [TAG_W-1:0] tg);
    lat = -1; pulses = 0; acc = 1'bx; tg = 'x;
    bus.req_valid = 1'b1; bus.req_de_idx = idx; bus.req_tag = tag; bus.rng_data = rd;
    step();
    bus.req_valid = 1'b0;
    if (eval_wr) begin
      cfg_we = 1'b1; cfg_sel = 1'b1; cfg_data = eval_data;
    end
    for (int c = 1; c <= 10; c++) begin
      if (bus.rng_enable) pulses++;
      if (bus.resp_valid) begin
        lat = c; acc = bus.resp_accept; tg = bus.resp_tag;
        break;
      end
      step();
      cfg_we = 1'b0;
    end
    cfg_we = 1'b0;
    if (lat >= 0) begin
      bus.resp_ready = 1'b1;
      step();
      bus.resp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
    checks++; if (bus.rng_enable !== 1'b0) begin failures++; $display("FAIL reset_rng_enable got=%b exp=0", bus.rng_enable); end
    checks++; if (bus.resp_accept !== 1'b0 || bus.resp_tag !== '0) begin failures++; $display("FAIL reset_resp_payload got=%b/%h exp=0/000", bus.resp_accept, bus.resp_tag); end
    checks++; if (accept_cnt !== '0 || draw_cnt !== '0) begin failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", accept_cnt, draw_cnt); end
    checks++; if (err_illegal !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_illegal); end
    checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_no_draw();
    int lat, pulses; logic acc; logic [TAG_W-1:0] tg;
    run_req(3'd1, 12'h05A, 16'hFFFF, 1'b0, '0, lat, pulses, acc, tg);
    checks++; if (lat !== 2) begin failures++; $display("FAIL nodraw_latency got=%0d exp=2", lat); end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL nodraw_rng_pulses got=%0d exp=0", pulses); end
    checks++; if (acc !== 1'b1 || tg !== 12'h05A) begin failures++; $display("FAIL nodraw_resp got=%b/%h exp=1/05a", acc, tg); end
    checks++; if (accept_cnt !== 32'd1 || draw_cnt !== 32'd0) begin failures++; $display("FAIL nodraw_counts got=%0d/%0d exp=1/0", accept_cnt, draw_cnt); end
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL nodraw_ready_after got=%b exp=1", bus.req_ready); end
    run_req(3'd0, 12'h001, 16'h0000, 1'b0, '0, lat, pulses, acc, tg);
    checks++; if (acc !== 1'b1 || pulses !== 0 || tg !== 12'h001) begin failures++; $display("FAIL idx0_resp got=%b/%0d/%h exp=1/0/001", acc, pulses, tg); end
    run_req(3'd2, 12'hFFF, 16'h0000, 1'b0, '0, lat, pulses, acc, tg);
    checks++; if (acc !== 1'b1 || pulses !== 0 || lat !== 2) begin failures++; $display("FAIL idx2_resp got=%b/%0d/%0d exp=1/0/2", acc, pulses, lat); end
    checks++; if (accept_cnt !== 32'd3) begin failures++; $display("FAIL nodraw_accept_cnt got=%0d exp=3", accept_cnt); end
  endtask

  task automatic test_thr4();
    int lat, pulses; logic acc; logic [TAG_W-1:0] tg;
    pulse_clr();
    checks++; if (accept_cnt !== '0 || draw_cnt !== '0) begin failures++; $display("FAIL clr_counts got=%0d/%0d exp=0/0", accept_cnt, draw_cnt); end
    cfg_write(1'b0, 16'h8000);
    run_req(3'd3, 12'h123, 16'h1234, 1'b0, '0, lat, pulses, acc, tg);
    checks++; if (lat !== 2 || pulses !== 1) begin failures++; $display("FAIL thr4_draw got=lat%0d/pulses%0d exp=lat2/pulses1", lat, pulses); end
    checks++; if (acc !== 1'b1 || tg !== 12'h123) begin failures++; $display("FAIL thr4_low_accept got=%b/%h exp=1/123", acc, tg); end
    run_req(3'd3, 12'h124, 16'h9000, 1'b0, '0, lat, pulses, acc, tg);
    checks++; if (acc !== 1'b0 || pulses !== 1) begin failures++; $display("FAIL thr4_high_reject got=%b/%0d exp=0/1", acc, pulses); end
    checks++; if (draw_cnt !== 32'd2 || accept_cnt !== 32'd1) begin failures++; $display("FAIL thr4_counts got=%0d/%0d exp=2/1", draw_cnt, accept_cnt); end
    run_req(3'd3, 12'h125, 16'h7FFF, 1'b0, '0, lat, pulses, acc, tg);
    checks++; if (acc !== 1'b1) begin failures++; $display("FAIL thr4_below_edge got=%b exp=1", acc); end
    run_req(3'd3, 12'h126, 16'h8000, 1'b0, '0, lat, pulses, acc, tg);
    checks++; if (acc !== 1'b0) begin failures++; $display("FAIL thr4_equal_edge got=%b exp=0", acc); end
  endtask

  task automatic test_thr8();
    int lat, pulses; logic acc; logic [TAG_W-1:0] tg;
    run_req(3'd4, 12'h100, 16'h0000, 1'b0, '0, lat, pulses, acc, tg);
    checks++; if (acc !== 1'b0 || pulses !== 1) begin failures++; $display("FAIL thr8_reset_reject got=%b/%0d exp=0/1", acc, pulses); end
    run_req(3'd4, 12'h101, 16'h0000, 1'b1, 16'hFFFF, lat, pulses, acc, tg);
    checks++; if (acc !== 1'b0 || lat !== 2) begin failures++; $display("FAIL thr8_write_in_eval got=%b/%0d exp=0/2", acc, lat); end
    run_req(3'd4, 12'h102, 16'h0000, 1'b0, '0, lat, pulses, acc, tg);
    checks++; if (acc !== 1'b1) begin failures++; $display("FAIL thr8_new_value got=%b exp=1", acc); end
    run_req(3'd4, 12'h103, 16'hFFFE, 1'b0, '0, lat, pulses, acc, tg);
    checks++; if (acc !== 1'b1) begin failures++; $display("FAIL thr8_fffe got=%b exp=1", acc); end
    run_req(3'd4, 12'h104, 16'hFFFF, 1'b0, '0, lat, pulses, acc, tg);
    checks++; if (acc !== 1'b0) begin failures++; $display("FAIL thr8_ffff got=%b exp=0", acc); end
    checks++; if (draw_cnt !== 32'd9 || accept_cnt !== 32'd4) begin failures++; $display("FAIL thr8_counts got=%0d/%0d exp=9/4", draw_cnt, accept_cnt); end
  endtask

  task automatic test_backpressure();
    bus.req_valid = 1'b1; bus.req_de_idx = 3'd0; bus.req_tag = 12'h3C3; bus.rng_data = 16'h0000;
    step();
    bus.req_valid = 1'b0;
    step();
    // A competing positive-energy request is offered while the response is stalled
    bus.req_valid = 1'b1; bus.req_de_idx = 3'd3; bus.req_tag = 12'h0AA;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_accept !== 1'b1 || bus.resp_tag !== 12'h3C3 ||
          bus.req_ready !== 1'b0 || bus.rng_enable !== 1'b0) begin
        failures++;
        $display("FAIL stall_cycle%0d got=v%b a%b t%h r%b e%b exp=v1 a1 t3c3 r0 e0", c,
                 bus.resp_valid, bus.resp_accept, bus.resp_tag, bus.req_ready, bus.rng_enable);
      end
      step();
    end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin failures++; $display("FAIL stall_release got=r%b v%b exp=r1 v0", bus.req_ready, bus.resp_valid); end
    checks++; if (accept_cnt !== 32'd5 || draw_cnt !== 32'd9) begin failures++; $display("FAIL stall_counts got=%0d/%0d exp=5/9", accept_cnt, draw_cnt); end
  endtask

  task automatic test_illegal();
    int lat, pulses; logic acc; logic [TAG_W-1:0] tg;
    run_req(3'd6, 12'h777, 16'h0000, 1'b0, '0, lat, pulses, acc, tg);
    checks++; if (lat !== 2 || pulses !== 0 || acc !== 1'b0 || tg !== 12'h777) begin failures++; $display("FAIL illegal_resp got=%0d/%0d/%b/%h exp=2/0/0/777", lat, pulses, acc, tg); end
    checks++; if (err_illegal !== 1'b1 || draw_cnt !== 32'd9) begin failures++; $display("FAIL illegal_flag got=%b/%0d exp=1/9", err_illegal, draw_cnt); end
    run_req(3'd2, 12'h778, 16'h0000, 1'b0, '0, lat, pulses, acc, tg);
    checks++; if (err_illegal !== 1'b1) begin failures++; $display("FAIL illegal_sticky got=%b exp=1", err_illegal); end
    // clear lands on the same edge as an accepted response handshake
    bus.req_valid = 1'b1; bus.req_de_idx = 3'd1; bus.req_tag = 12'h779;
    step();
    bus.req_valid = 1'b0;
    step();
    bus.resp_ready = 1'b1; stat_clr = 1'b1;
    step();
    bus.resp_ready = 1'b0; stat_clr = 1'b0;
    checks++; if (err_illegal !== 1'b0 || accept_cnt !== '0 || draw_cnt !== '0) begin failures++; $display("FAIL clr_priority got=%b/%0d/%0d exp=0/0/0", err_illegal, accept_cnt, draw_cnt); end
  endtask

  task automatic test_reset_mid();
    int lat, pulses; logic acc; logic [TAG_W-1:0] tg;
    int seen;
    bus.req_valid = 1'b1; bus.req_de_idx = 3'd3; bus.req_tag = 12'h555; bus.rng_data = 16'h0000;
    step();
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.rng_enable !== 1'b0 || bus.req_ready !== 1'b1) begin failures++; $display("FAIL midreset_async got=e%b r%b exp=e0 r1", bus.rng_enable, bus.req_ready); end
    step();
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.resp_valid !== 1'b0 || bus.rng_enable !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midreset_no_resp got=%0d exp=0", seen); end
    run_req(3'd3, 12'h556, 16'h0000, 1'b0, '0, lat, pulses, acc, tg);
    checks++; if (acc !== 1'b0 || pulses !== 1 || lat !== 2) begin failures++; $display("FAIL midreset_thr_cleared got=%b/%0d/%0d exp=0/1/2", acc, pulses, lat); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_de_idx = 3'd0; bus.req_tag = '0;
    bus.rng_data = '0; bus.resp_ready = 1'b0;
    cfg_we = 1'b0; cfg_sel = 1'b0; cfg_data = '0; stat_clr = 1'b0;
    test_reset();
    test_no_draw();
    test_thr4();
    test_thr8();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
